force_writeback_ctrl: RTL

- Downstream stage of the long-range electrostatics top level.
- Captures per-particle force triples (X/Y/Z, 32 bits each) produced by the three force reduction trees and packs each triple into one 128-bit word.
- Buffers the words in a local FIFO, since the reduction trees cannot be back-pressured.
- Drives a DMA write master (control_* / user_* handshake) that streams the words to host memory at a programmed base address, and reports completion and error status.

---
 rtl/force_writeback_ctrl_if.sv | 38 +++
 rtl/force_writeback_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/force_writeback_ctrl_if.sv
// rtl/force_writeback_ctrl_if.sv - DMA write-master control and user-buffer handshake bundle
interface force_writeback_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    control_fixed_location;
    logic [ADDR_WIDTH-1:0]   control_write_base;
    logic [ADDR_WIDTH-1:0]   control_write_length;
    logic                    control_go;
    logic                    control_done;
    logic                    user_write_buffer;
    logic [4*DATA_WIDTH-1:0] user_buffer_input_data;
    logic                    user_buffer_full;

    // Writeback controller side: launches transfers and pushes words
    modport master (
        output control_fixed_location,
        output control_write_base,
        output control_write_length,
        output control_go,
        input  control_done,
        output user_write_buffer,
        output user_buffer_input_data,
        input  user_buffer_full
    );

    // Write-master side: accepts words and reports completion
    modport slave (
        input  control_fixed_location,
        input  control_write_base,
        input  control_write_length,
        input  control_go,
        output control_done,
        input  user_write_buffer,
        input  user_buffer_input_data,
        output user_buffer_full
    );
endinterface

// File: rtl/force_writeback_ctrl.sv
// rtl/force_writeback_ctrl.sv - packs force triples into 128-bit words, buffers them and streams them to a DMA write master
module force_writeback_ctrl #(
    parameter int DATA_WIDTH      = 32,
    parameter int FIFO_DEPTH      = 16,
    parameter int FIFO_ADDR_WIDTH = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int COUNT_WIDTH     = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] num_particles,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic                   force_valid,
    input  logic [DATA_WIDTH-1:0]  force_x,
    input  logic [DATA_WIDTH-1:0]  force_y,
    input  logic [DATA_WIDTH-1:0]  force_z,
    force_writeback_ctrl_if.master dma,
    output logic                   busy,
    output logic                   done,
    output logic                   err_overflow,
    output logic                   err_unexpected
);
    localparam int PW = FIFO_ADDR_WIDTH + 1;
    localparam int WW = 4 * DATA_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_STREAM,
        S_WAIT_DONE,
        S_FINISH
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [COUNT_WIDTH-1:0] r_num;
    logic [COUNT_WIDTH-1:0] r_in_cnt;
    logic [COUNT_WIDTH-1:0] r_out_cnt;
    logic [ADDR_WIDTH-1:0]  r_base;
    logic                   r_err_overflow;
    logic                   r_err_unexpected;

    logic [WW-1:0]          r_mem [FIFO_DEPTH];
    logic [PW-1:0]          r_wr_ptr;
    logic [PW-1:0]          r_rd_ptr;

    logic                   w_fifo_empty;
    logic                   w_fifo_full;
    logic                   w_in_window;
    logic                   w_in_room;
    logic                   w_pop;
    logic                   w_capture;
    logic                   w_push;
    logic                   w_drop_full;
    logic                   w_stray;
    logic                   w_start_pass;
    logic [COUNT_WIDTH-1:0] w_in_cnt_next;
    logic [PW-1:0]          w_wr_ptr_next;
    logic [PW-1:0]          w_rd_ptr_next;
    logic                   w_stream_done;
    logic [WW-1:0]          w_push_word;

    // The extra pointer MSB tells a full FIFO (MSBs differ) from an empty one (pointers equal)
    assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
    assign w_fifo_full  = (r_wr_ptr[FIFO_ADDR_WIDTH-1:0] == r_rd_ptr[FIFO_ADDR_WIDTH-1:0]) &&
                          (r_wr_ptr[FIFO_ADDR_WIDTH] != r_rd_ptr[FIFO_ADDR_WIDTH]);

    // Triples are only wanted while the pass is armed or streaming and still short of num_particles
    assign w_in_window  = (r_state == S_ARM) || (r_state == S_STREAM);
    assign w_in_room    = (r_in_cnt < r_num);
    assign w_start_pass = (r_state == S_IDLE) && start;

    assign w_pop        = (r_state == S_STREAM) && !w_fifo_empty && !dma.user_buffer_full;
    assign w_capture    = force_valid && w_in_window && w_in_room;
    // A pop in the same cycle frees a slot, so a full FIFO still takes the push
    assign w_push       = w_capture && (!w_fifo_full || w_pop);
    assign w_drop_full  = w_capture && w_fifo_full && !w_pop;
    assign w_stray      = force_valid && !(w_in_window && w_in_room);
    assign w_push_word  = {{DATA_WIDTH{1'b0}}, force_z, force_y, force_x};

    assign w_in_cnt_next = w_capture ? (r_in_cnt + COUNT_WIDTH'(1)) : r_in_cnt;
    assign w_wr_ptr_next = w_push ? (r_wr_ptr + PW'(1)) : r_wr_ptr;
    assign w_rd_ptr_next = w_pop  ? (r_rd_ptr + PW'(1)) : r_rd_ptr;

    // Dropped words never get strobed, so the pass also ends once every triple has arrived and the FIFO drains
    assign w_stream_done = (w_pop && ((r_out_cnt + COUNT_WIDTH'(1)) == r_num)) ||
                           ((w_in_cnt_next == r_num) && (w_wr_ptr_next == w_rd_ptr_next));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; start outside IDLE and control_done outside WAIT_DONE are ignored
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = (num_particles == '0) ? S_FINISH : S_ARM;
                end
            end
            S_ARM:       w_state_next = S_STREAM;
            S_STREAM: begin
                if (w_stream_done) begin
                    w_state_next = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (dma.control_done) begin
                    w_state_next = S_FINISH;
                end
            end
            S_FINISH:    w_state_next = S_IDLE;
            default:     w_state_next = S_IDLE;
        endcase
    end

    // Pass parameters latched on start; in/out counters track captured and strobed words
    always_ff @(posedge clk) begin
        if (rst) begin
            r_num     <= '0;
            r_base    <= '0;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
        end else if (w_start_pass) begin
            r_num     <= num_particles;
            r_base    <= base_addr;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
        end else begin
            r_in_cnt <= w_in_cnt_next;
            if (w_pop) begin
                r_out_cnt <= r_out_cnt + COUNT_WIDTH'(1);
            end
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[FIFO_ADDR_WIDTH-1:0]] <= w_push_word;
        end
    end

    // FIFO pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_next;
            r_rd_ptr <= w_rd_ptr_next;
        end
    end

    // Sticky error flags, cleared by the start of a new pass
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_overflow   <= 1'b0;
            r_err_unexpected <= 1'b0;
        end else begin
            if (w_start_pass) begin
                r_err_overflow   <= 1'b0;
                r_err_unexpected <= 1'b0;
            end
            if (w_drop_full) begin
                r_err_overflow <= 1'b1;
            end
            if (w_stray) begin
                r_err_unexpected <= 1'b1;
            end
        end
    end

    assign dma.control_fixed_location = 1'b0;
    assign dma.control_write_base     = r_base;
    assign dma.control_write_length   = ADDR_WIDTH'({r_num, 4'b0000});
    assign dma.control_go             = (r_state == S_ARM);
    assign dma.user_write_buffer      = w_pop;
    // Show-ahead head; forced to zero when nothing is presentable so idle outputs stay quiet
    assign dma.user_buffer_input_data = ((r_state == S_STREAM) && !w_fifo_empty) ?
                                        r_mem[r_rd_ptr[FIFO_ADDR_WIDTH-1:0]] : '0;

    assign busy           = (r_state != S_IDLE);
    assign done           = (r_state == S_FINISH);
    assign err_overflow   = r_err_overflow;
    assign err_unexpected = r_err_unexpected;
endmodule
